// File: rtl/alu_arb_pkg.sv
// Arbiter-local types and sizes: FSM state encoding, requester count, counter width.
package alu_arb_pkg;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned PERF_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: default datapath widths and the opcode encoding.
// Opcodes pass through the arbiter untouched; only the external ALU decodes them.
package alu_defs_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned ALU_OP_WIDTH = 4;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'd9;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin grant selector (purely combinational).
// Ports:
//   valid      in  2  request valid per requester
//   last_grant in  1  requester served most recently
//   grant      out 1  selected requester (meaningful only when valid != 0)
module rr_pick2
    import alu_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last_grant,
    output logic               grant
);

    // On a tie the requester not served last wins; otherwise the lone valid one.
    always_comb begin
        grant = valid[1];
        if (valid[0] && valid[1]) begin
            grant = ~last_grant;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared external ALU.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (ALU evaluates)
// -> RESP (hold result until the granted requester consumes it).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready [2]         request handshake per requester
//   req_src1_i/req_src2_i/req_op_i  operands and opcode of requester i
//   rsp_valid [2], rsp_ready [2]    response handshake per requester
//   rsp_result, rsp_zero            shared response payload
//   alu_src1/alu_src2/alu_op        operands to the external ALU (held when idle)
//   alu_result, alu_zero            external ALU outputs
//   perf_ops_0/1, perf_stall        saturating counters, only with ALU_ARB_PERF_EN
// Optional feature macro: ALU_ARB_PERF_EN
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned XLEN         = alu_defs_pkg::XLEN,
    parameter int unsigned ALU_OP_WIDTH = alu_defs_pkg::ALU_OP_WIDTH
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [XLEN-1:0]         req_src1_0,
    input  logic [XLEN-1:0]         req_src2_0,
    input  logic [ALU_OP_WIDTH-1:0] req_op_0,
    input  logic [XLEN-1:0]         req_src1_1,
    input  logic [XLEN-1:0]         req_src2_1,
    input  logic [ALU_OP_WIDTH-1:0] req_op_1,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]         rsp_result,
    output logic                    rsp_zero,
`ifdef ALU_ARB_PERF_EN
    output logic [PERF_CNT_W-1:0]   perf_ops_0,
    output logic [PERF_CNT_W-1:0]   perf_ops_1,
    output logic [PERF_CNT_W-1:0]   perf_stall,
`endif
    output logic [XLEN-1:0]         alu_src1,
    output logic [XLEN-1:0]         alu_src2,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    input  logic [XLEN-1:0]         alu_result,
    input  logic                    alu_zero
);

    arb_state_e              state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    grant_q, grant_d;
    logic [XLEN-1:0]         src1_q, src1_d;
    logic [XLEN-1:0]         src2_q, src2_d;
    logic [ALU_OP_WIDTH-1:0] op_q, op_d;
    logic [XLEN-1:0]         rsp_result_q, rsp_result_d;
    logic                    rsp_zero_q, rsp_zero_d;

    logic                    pick_c;
    logic [NUM_REQ-1:0]      req_ready_c;
    logic [NUM_REQ-1:0]      rsp_valid_c;
    logic                    req_hs_c;
    logic                    rsp_hs_c;

    rr_pick2 u_pick (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_c)
    );

    // Next-state, capture and handshake decode.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        op_d         = op_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        req_ready_c  = '0;
        rsp_valid_c  = '0;
        req_hs_c     = 1'b0;
        rsp_hs_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid[pick_c]) begin
                    req_ready_c[pick_c] = 1'b1;
                    req_hs_c            = 1'b1;
                    grant_d             = pick_c;
                    last_grant_d        = pick_c;
                    src1_d              = pick_c ? req_src1_1 : req_src1_0;
                    src2_d              = pick_c ? req_src2_1 : req_src2_0;
                    op_d                = pick_c ? req_op_1   : req_op_0;
                    state_d             = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_c[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    rsp_hs_c = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            op_q         <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            op_q         <= op_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    // req_ready is a same-cycle accept, so it must also be forced low while in reset.
    assign req_ready  = req_ready_c & {NUM_REQ{rst_n}};
    assign rsp_valid  = rsp_valid_c;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    // ALU operands come straight from the capture registers, so they only move on accept.
    assign alu_src1   = src1_q;
    assign alu_src2   = src2_q;
    assign alu_op     = op_q;

`ifdef ALU_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] ops0_q, ops0_d;
    logic [PERF_CNT_W-1:0] ops1_q, ops1_d;
    logic [PERF_CNT_W-1:0] stall_q, stall_d;

    // Saturating event counters.
    always_comb begin
        ops0_d  = ops0_q;
        ops1_d  = ops1_q;
        stall_d = stall_q;
        if (rsp_hs_c && !grant_q && (ops0_q != '1)) begin
            ops0_d = ops0_q + PERF_CNT_W'(1);
        end
        if (rsp_hs_c && grant_q && (ops1_q != '1)) begin
            ops1_d = ops1_q + PERF_CNT_W'(1);
        end
        if ((req_valid != '0) && !req_hs_c && (stall_q != '1)) begin
            stall_d = stall_q + PERF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops0_q  <= '0;
            ops1_q  <= '0;
            stall_q <= '0;
        end else begin
            ops0_q  <= ops0_d;
            ops1_q  <= ops1_d;
            stall_q <= stall_d;
        end
    end

    assign perf_ops_0 = ops0_q;
    assign perf_ops_1 = ops1_q;
    assign perf_stall = stall_q;
`else
    // Counters compiled out; the handshake strobes have no other consumer.
    logic unused_c;
    assign unused_c = req_hs_c ^ rsp_hs_c;
`endif

endmodule
